mmio_port_responder: RTL and testbench

MMIO_PORT_RESPONDER -- requirements
Module: mmio_port_responder

---
 rtl/mmio_pkg.sv | 53 +++++
 rtl/sync_edge_detect.sv | 33 +++
 rtl/mmio_port_responder.sv | 123 ++++++++++++
 tb/tb_mmio_port_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared register map, bit positions and reset constants for the MMIO port
// responder, plus the offset decoder used by its read and write paths.
package mmio_pkg;

    // Byte offsets within the 256-byte peripheral window
    localparam logic [7:0] OFF_PORT_OUT  = 8'h00;
    localparam logic [7:0] OFF_PORT_IN   = 8'h04;
    localparam logic [7:0] OFF_STATUS    = 8'h08;
    localparam logic [7:0] OFF_TIMER_CNT = 8'h0C;
    localparam logic [7:0] OFF_TIMER_CMP = 8'h10;
    localparam logic [7:0] OFF_CTRL      = 8'h14;

    // STATUS bits (write-one-to-clear)
    localparam int unsigned STATUS_W   = 2;
    localparam int unsigned STAT_CHG   = 0;
    localparam int unsigned STAT_TMR   = 1;

    // CTRL bits
    localparam int unsigned CTRL_W      = 4;
    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_RELOAD = 1;
    localparam int unsigned CTRL_IE_CHG = 2;
    localparam int unsigned CTRL_IE_TMR = 3;

    localparam logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        REG_PORT_OUT,
        REG_PORT_IN,
        REG_STATUS,
        REG_TIMER_CNT,
        REG_TIMER_CMP,
        REG_CTRL,
        REG_NONE
    } reg_sel_e;

    // Map a window offset to a register; misaligned or unmapped offsets
    // fall through to REG_NONE so they neither read nor write anything.
    function automatic reg_sel_e decode_offset(input logic [7:0] offset);
        reg_sel_e sel;
        case (offset)
            OFF_PORT_OUT:  sel = REG_PORT_OUT;
            OFF_PORT_IN:   sel = REG_PORT_IN;
            OFF_STATUS:    sel = REG_STATUS;
            OFF_TIMER_CNT: sel = REG_TIMER_CNT;
            OFF_TIMER_CMP: sel = REG_TIMER_CMP;
            OFF_CTRL:      sel = REG_CTRL;
            default:       sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous bus, with a change flag that is
// high in the cycle before the synchronized value updates, so a register
// loaded from it records the change on the same edge the new value appears.
module sync_edge_detect #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             changed
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    // Synchronizer chain: metastability settles in stage1, stage2 is safe to use
    // NOTE: async active-low reset sits in the sensitivity list so it clears the flops without a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: non-blocking assignments let stage2 take stage1's old value on the same edge.
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= din;
            stage2_q <= stage1_q;
        end
    end

    assign dout    = stage2_q;
    assign changed = (stage1_q != stage2_q);

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O peripheral: output port, synchronized input port with
// change detection, a free-running/one-shot compare timer and a level IRQ.
// The read path is combinational so loads complete in the MEM stage.
module mmio_port_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          IN_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    output logic [31:0]         ReadData,
    output logic                Sel,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         PortOut,
    output logic                Irq
);

    logic [31:0]         port_out_q;
    logic [31:0]         timer_cnt_q;
    logic [31:0]         timer_cmp_q;
    logic [CTRL_W-1:0]   ctrl_q;
    logic [STATUS_W-1:0] status_q;
    logic [IN_WIDTH-1:0] port_in_sync;
    logic                port_in_changed;

    reg_sel_e            reg_sel;
    logic                wr_en;
    logic                timer_match;
    logic [STATUS_W-1:0] status_set;
    logic [STATUS_W-1:0] status_clr;
    logic [31:0]         read_data;

    sync_edge_detect #(
        .WIDTH (IN_WIDTH)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .din     (PortIn),
        .dout    (port_in_sync),
        .changed (port_in_changed)
    );

    assign Sel         = (Address[31:8] == BASE_ADDR[31:8]);
    assign reg_sel     = decode_offset(Address[7:0]);
    assign wr_en       = MemWrite && Sel;
    assign timer_match = ctrl_q[CTRL_EN] && (timer_cnt_q == timer_cmp_q);

    // Hardware events that set STATUS, and the software W1C mask; set wins below
    assign status_set           = {timer_match, port_in_changed};
    assign status_clr           = (wr_en && reg_sel == REG_STATUS) ? WriteData[STATUS_W-1:0] : '0;

    // Software-only registers: output port and timer compare value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_out_q  <= '0;
            timer_cmp_q <= TIMER_CMP_RST;
        end else if (wr_en) begin
            if (reg_sel == REG_PORT_OUT)  port_out_q  <= WriteData;
            if (reg_sel == REG_TIMER_CMP) timer_cmp_q <= WriteData;
        end
    end

    // Timer counter: software write first, then match handling, then increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_cnt_q <= '0;
        end else if (wr_en && reg_sel == REG_TIMER_CNT) begin
            timer_cnt_q <= WriteData;
        end else if (timer_match) begin
            if (ctrl_q[CTRL_RELOAD]) timer_cnt_q <= '0;
        end else if (ctrl_q[CTRL_EN]) begin
            timer_cnt_q <= timer_cnt_q + 32'd1;
        end
    end

    // Control register: a one-shot match drops EN unless software writes CTRL
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= '0;
        end else if (wr_en && reg_sel == REG_CTRL) begin
            ctrl_q <= WriteData[CTRL_W-1:0];
        end else if (timer_match && !ctrl_q[CTRL_RELOAD]) begin
            ctrl_q[CTRL_EN] <= 1'b0;
        end
    end

    // Sticky status flags: cleared by writing ones, hardware set takes priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_q <= '0;
        end else begin
            status_q <= (status_q & ~status_clr) | status_set;
        end
    end

    // Zero-latency read mux; unselected or unmapped accesses return zero
    always_comb begin
        // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
        read_data = '0;
        if (MemRead && Sel) begin
            case (reg_sel)
                REG_PORT_OUT:  read_data = port_out_q;
                REG_PORT_IN:   read_data = 32'(port_in_sync);
                REG_STATUS:    read_data = 32'(status_q);
                REG_TIMER_CNT: read_data = timer_cnt_q;
                REG_TIMER_CMP: read_data = timer_cmp_q;
                REG_CTRL:      read_data = 32'(ctrl_q);
                default:       read_data = '0;
            endcase
        end
    end

    assign ReadData = read_data;
    assign PortOut  = port_out_q;
    assign Irq      = (status_q[STAT_CHG] && ctrl_q[CTRL_IE_CHG]) ||
                      (status_q[STAT_TMR] && ctrl_q[CTRL_IE_TMR]);

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder: register access, input sync and
// change flag, timer reload and one-shot modes, W1C collision, reset abort.
`timescale 1ns/1ps
module tb_mmio_port_responder;

    localparam logic [31:0] BASE   = 32'hFFFF_0000;
    localparam logic [31:0] A_OUT  = BASE + 32'h00;
    localparam logic [31:0] A_IN   = BASE + 32'h04;
    localparam logic [31:0] A_STAT = BASE + 32'h08;
    localparam logic [31:0] A_CNT  = BASE + 32'h0C;
    localparam logic [31:0] A_CMP  = BASE + 32'h10;
    localparam logic [31:0] A_CTRL = BASE + 32'h14;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Sel;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic        Irq;

    int pass_count = 0;
    int fail_count = 0;
    int total      = 0;

    mmio_port_responder #(
        .BASE_ADDR (BASE),
        .IN_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Sel       (Sel),
        .PortIn    (PortIn),
        .PortOut   (PortOut),
        .Irq       (Irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        Address = addr;
        MemRead = 1'b1;
        #1;
        check(tag, ReadData, exp);
        MemRead = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = 32'h0;
        WriteData = 32'h0;
        PortIn    = 8'h00;

        // Reset state
        #15;
        check("rst_portout", PortOut, 32'h0);
        check("rst_irq", Irq, 32'h0);
        check("rst_readdata", ReadData, 32'h0);
        check("rst_sel", Sel, 32'h0);
        reset = 1'b1;
        tick(1);
        rd_check("rst_cmp", A_CMP, 32'hFFFF_FFFF);
        rd_check("rst_status", A_STAT, 32'h0);
        rd_check("rst_ctrl", A_CTRL, 32'h0);

        // Window decode
        Address = BASE;             #1; check("sel_base", Sel, 32'h1);
        Address = 32'hFFFE_0000;    #1; check("sel_out", Sel, 32'h0);
        Address = BASE + 32'hFC;    #1; check("sel_top", Sel, 32'h1);
        tick(1);

        // PORT_OUT write and read back
        bus_write(A_OUT, 32'h0000_00A5);
        check("portout_a5", PortOut, 32'h0000_00A5);
        rd_check("rd_portout", A_OUT, 32'h0000_00A5);
        Address = A_OUT; MemRead = 1'b0; #1;
        check("rd_no_strobe", ReadData, 32'h0);
        Address = 32'h0000_0000; MemRead = 1'b1; #1;
        check("rd_outside_win", ReadData, 32'h0);
        MemRead = 1'b0;
        tick(1);

        // Simultaneous read and write: read shows the old value
        Address = A_OUT; WriteData = 32'h0000_005A; MemRead = 1'b1; MemWrite = 1'b1; #1;
        check("rw_pre_value", ReadData, 32'h0000_00A5);
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        check("rw_commit", PortOut, 32'h0000_005A);

        // Misaligned and unmapped accesses
        bus_write(BASE + 32'h02, 32'hFFFF_FFFF);
        check("misalign_wr", PortOut, 32'h0000_005A);
        rd_check("misalign_rd", BASE + 32'h02, 32'h0);
        bus_write(BASE + 32'h40, 32'hFFFF_FFFF);
        rd_check("unmapped_rd", BASE + 32'h40, 32'h0);
        bus_write(BASE + 32'h15, 32'h0000_000F);
        rd_check("misalign_ctrl", A_CTRL, 32'h0);
        rd_check("unmapped_cmp", A_CMP, 32'hFFFF_FFFF);
        check("unmapped_portout", PortOut, 32'h0000_005A);

        // Input port synchronizer and change flag
        tick(1);
        PortIn = 8'h3C;
        tick(1);
        rd_check("portin_1edge", A_IN, 32'h0);
        tick(1);
        rd_check("portin_2edge", A_IN, 32'h0000_003C);
        tick(1);
        rd_check("chg_status", A_STAT, 32'h1);
        check("chg_irq_masked", Irq, 32'h0);
        bus_write(A_CTRL, 32'hFFFF_FF04);
        rd_check("ctrl_upper_zero", A_CTRL, 32'h4);
        check("chg_irq", Irq, 32'h1);
        bus_write(A_STAT, 32'h1);
        check("chg_irq_clr", Irq, 32'h0);
        rd_check("chg_status_clr", A_STAT, 32'h0);
        bus_write(A_CTRL, 32'h0);

        // Timer with reload: match at 5, period 6
        bus_write(A_CMP, 32'd5);
        bus_write(A_CTRL, 32'hB);
        rd_check("rl_cnt0", A_CNT, 32'd0);
        tick(5);
        rd_check("rl_cnt5", A_CNT, 32'd5);
        rd_check("rl_stat_pre", A_STAT, 32'h0);
        check("rl_irq_pre", Irq, 32'h0);
        tick(1);
        rd_check("rl_cnt_wrap", A_CNT, 32'd0);
        rd_check("rl_tmr_set", A_STAT, 32'h2);
        check("rl_irq", Irq, 32'h1);
        bus_write(A_STAT, 32'h2);
        rd_check("rl_tmr_clr", A_STAT, 32'h0);
        check("rl_irq_clr", Irq, 32'h0);
        rd_check("rl_cnt1", A_CNT, 32'd1);
        tick(4);
        rd_check("rl2_cnt5", A_CNT, 32'd5);
        rd_check("rl2_stat_pre", A_STAT, 32'h0);
        tick(1);
        rd_check("rl2_tmr_set", A_STAT, 32'h2);
        rd_check("rl2_cnt0", A_CNT, 32'd0);
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STAT, 32'h3);
        rd_check("rl_stat_final", A_STAT, 32'h0);

        // One-shot timer: holds at compare value and drops EN
        bus_write(A_CNT, 32'd0);
        bus_write(A_CMP, 32'd3);
        bus_write(A_CTRL, 32'h1);
        tick(3);
        rd_check("os_cnt3", A_CNT, 32'd3);
        rd_check("os_ctrl_en", A_CTRL, 32'h1);
        tick(1);
        rd_check("os_cnt_hold", A_CNT, 32'd3);
        rd_check("os_ctrl_clr", A_CTRL, 32'h0);
        rd_check("os_tmr", A_STAT, 32'h2);
        tick(2);
        rd_check("os_cnt_hold2", A_CNT, 32'd3);
        bus_write(A_STAT, 32'h2);

        // W1C collides with a timer set: the set wins
        bus_write(A_CNT, 32'd0);
        bus_write(A_CMP, 32'd2);
        bus_write(A_CTRL, 32'h3);
        tick(2);
        rd_check("col_cnt2", A_CNT, 32'd2);
        bus_write(A_STAT, 32'h2);
        rd_check("col_set_wins", A_STAT, 32'h2);
        rd_check("col_cnt_reload", A_CNT, 32'd0);
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STAT, 32'h2);
        rd_check("col_clear", A_STAT, 32'h0);

        // Reset mid-count aborts everything at once
        PortIn = 8'h00;
        bus_write(A_CNT, 32'h10);
        bus_write(A_CMP, 32'h100);
        bus_write(A_CTRL, 32'h5);
        rd_check("pre_rst_stat", A_STAT, 32'h1);
        rd_check("pre_rst_cnt", A_CNT, 32'h10);
        check("pre_rst_irq", Irq, 32'h1);
        reset = 1'b0;
        #1;
        check("mid_rst_portout", PortOut, 32'h0);
        check("mid_rst_irq", Irq, 32'h0);
        rd_check("mid_rst_cnt", A_CNT, 32'h0);
        rd_check("mid_rst_ctrl", A_CTRL, 32'h0);
        rd_check("mid_rst_cmp", A_CMP, 32'hFFFF_FFFF);
        rd_check("mid_rst_stat", A_STAT, 32'h0);
        reset = 1'b1;
        tick(3);
        rd_check("post_rst_cnt", A_CNT, 32'h0);
        rd_check("post_rst_ctrl", A_CTRL, 32'h0);
        check("post_rst_irq", Irq, 32'h0);

        $display("%0d/%0d checks passed", pass_count, total);
        $finish;
    end

endmodule
